icache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage and the backing instruction memory. Hits return the instruction combinationally in the same cycle. A miss stalls fetch and runs a line refill over a one-beat-per-word ready handshake, then resumes with a hit. A fence.i-style invalidate input clears every line.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_data_array.sv | 28 ++
 rtl/icache.sv | 158 +++++++++++++++
 tb/tb_icache.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache shared types and address-split helpers.
// Geometry is derived from the module parameters.
package icache_pkg;

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int offset_w(input int wpl);
    return $clog2(wpl) + 2;
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(
    input int aw,
    input int sets,
    input int wpl
  );
    return aw - index_w(sets) - offset_w(wpl);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// icache word storage: one write port, one async read port.
// Contents are not reset; valid bits gate every read.
module icache_data_array #(
  parameter int DW   = 32,
  parameter int SETS = 64,
  parameter int WPL  = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(SETS)-1:0] widx,
  input  logic [$clog2(WPL)-1:0]  wword,
  input  logic [DW-1:0]           wdata,
  input  logic [$clog2(SETS)-1:0] ridx,
  input  logic [$clog2(WPL)-1:0]  rword,
  output logic [DW-1:0]           rdata
);

  logic [DW-1:0] mem [SETS][WPL];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx][wword] <= wdata;
    end
  end

  assign rdata = mem[ridx][rword];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// Zero-cycle hits, stalling line refill on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  invalidate_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  hit_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam int OFFSET_W =
    offset_w(WORDS_PER_LINE);
  localparam int INDEX_W = index_w(SETS);
  localparam int TAG_W =
    tag_w(ADDR_WIDTH, SETS, WORDS_PER_LINE);
  localparam int BEAT_W = OFFSET_W - 2;
  localparam int LINE_W = ADDR_WIDTH - OFFSET_W;
  localparam logic [BEAT_W-1:0] LAST =
    BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [DATA_WIDTH-1:0] NOP_W =
    DATA_WIDTH'(NOP);

  state_e state, nstate;

  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags [SETS];
  logic [LINE_W-1:0]  miss_line;
  logic [BEAT_W-1:0]  beat;
  logic               pending;

  logic [BEAT_W-1:0]  aword;
  logic [INDEX_W-1:0] aidx, midx;
  logic [TAG_W-1:0]   atag, mtag;
  logic [DATA_WIDTH-1:0] rdata;
  logic lookup, fill, done, start;
  logic unused_lsb;

  assign unused_lsb = ^addr_i[1:0];

  assign aword = addr_i[OFFSET_W-1:2];
  assign aidx  = addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign atag  = addr_i[ADDR_WIDTH-1:OFFSET_W+INDEX_W];
  assign midx  = miss_line[INDEX_W-1:0];
  assign mtag  = miss_line[LINE_W-1:INDEX_W];

  assign lookup = valid[aidx] && (tags[aidx] == atag);
  assign fill   = (state == REFILL) && mem_ready_i;
  assign done   = fill && (beat == LAST);
  assign start  = (state == IDLE) && (nstate == REFILL);

  icache_data_array #(
    .DW   (DATA_WIDTH),
    .SETS (SETS),
    .WPL  (WORDS_PER_LINE)
  ) u_data (
    .clk   (clk),
    .we    (fill),
    .widx  (midx),
    .wword (beat),
    .wdata (mem_rdata_i),
    .ridx  (aidx),
    .rword (aword),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      miss_line <= '0;
    end else begin
      state <= nstate;
      if (start) begin
        beat      <= '0;
        miss_line <= addr_i[ADDR_WIDTH-1:OFFSET_W];
      end else if (fill) begin
        beat <= beat + 1'b1;
      end
    end
  end

  // An invalidate landing mid-refill must also kill the line being filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= '0;
      pending <= 1'b0;
    end else begin
      if (invalidate_i) begin
        valid <= '0;
      end
      if (done && !pending && !invalidate_i) begin
        valid[midx] <= 1'b1;
      end
      if (done) begin
        pending <= 1'b0;
      end else if ((state == REFILL) && invalidate_i) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done) begin
      tags[midx] <= mtag;
    end
  end

  always_comb begin
    nstate     = state;
    instr_o    = NOP_W;
    hit_o      = 1'b0;
    stall_o    = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    unique case (1'b1)
      (state == IDLE): begin
        hit_o = req_i && lookup;
        if (hit_o) begin
          instr_o = rdata;
        end else if (req_i) begin
          stall_o = 1'b1;
          nstate  = REFILL;
        end
      end
      (state == REFILL): begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_line, beat, 2'b00};
        if (done) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
    if (!rst) begin
      instr_o    = NOP_W;
      hit_o      = 1'b0;
      stall_o    = 1'b0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
    end
  end

endmodule

// File: tb/tb_icache.sv
// icache bench: line-level cache model plus directed vectors.
// Backing memory returns a fixed function of the word address.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        invalidate_i = 1'b0;
  logic [31:0] instr_o;
  logic        hit_o, stall_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int stall_cnt = 0;
  logic [31:0] beats [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(
    input logic [31:0] a
  );
    return {~a[15:0], a[15:0]};
  endfunction

  assign mem_rdata_i = memword(mem_addr_o);

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .invalidate_i (invalidate_i),
    .instr_o      (instr_o),
    .hit_o        (hit_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Model: which line each set holds, plus an in-flight refill.
  bit          mval  [64];
  logic [31:0] mline [64];
  bit          busy = 0;
  bit          pend = 0;
  int          nbeat = 0;
  logic [31:0] rline = '0;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) & 32'h3f);
  endfunction

  function automatic bit present(input logic [31:0] a);
    return mval[set_of(a)] &&
           mline[set_of(a)] == (a & ~32'hf);
  endfunction

  always @(posedge clk) begin : model
    bit pn;
    int s;
    if (!rst) begin
      busy  <= 0;
      pend  <= 0;
      nbeat <= 0;
      for (int i = 0; i < 64; i++) mval[i] <= 0;
    end else if (!busy) begin
      if (invalidate_i)
        for (int i = 0; i < 64; i++) mval[i] <= 0;
      if (req_i && !present(addr_i)) begin
        busy  <= 1;
        rline <= addr_i & ~32'hf;
        nbeat <= 0;
      end
    end else begin
      pn = pend | invalidate_i;
      pend <= pn;
      if (invalidate_i)
        for (int i = 0; i < 64; i++) mval[i] <= 0;
      if (mem_ready_i) begin
        if (nbeat == 3) begin
          s = set_of(rline);
          busy  <= 0;
          nbeat <= 0;
          pend  <= 0;
          mline[s] <= rline;
          mval[s]  <= !pn;
        end else begin
          nbeat <= nbeat + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit lk;
    logic [31:0] e_ins, e_ma;
    bit e_hit, e_st, e_mr;
    e_ins = 32'h13;
    e_hit = 0;
    e_st  = 0;
    e_mr  = 0;
    e_ma  = '0;
    if (rst && busy) begin
      e_st = 1;
      e_mr = 1;
      e_ma = rline + 32'(4 * nbeat);
    end else if (rst) begin
      lk    = req_i && present(addr_i);
      e_hit = lk;
      e_st  = req_i && !lk;
      if (lk) e_ins = memword(addr_i & ~32'h3);
    end
    chk("instr_o", instr_o, e_ins);
    chk("hit_o", 32'(hit_o), 32'(e_hit));
    chk("stall_o", 32'(stall_o), 32'(e_st));
    chk("mem_req_o", 32'(mem_req_o), 32'(e_mr));
    chk("mem_addr_o", mem_addr_o, e_ma);
    if (rst && stall_o) stall_cnt++;
    if (mem_req_o && mem_ready_i) beats.push_back(mem_addr_o);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hit(input string nm);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (hit_o) ok = 1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    nxt();
    nxt();
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_instr", instr_o, 32'h13);
    rst = 1'b1;
    nxt();

    // cold miss on 0x100
    stall_cnt = 0;
    beats.delete();
    req_i  = 1'b1;
    addr_i = 32'h100;
    wait_hit("fill100_timeout");
    chk("fill100_stalls", 32'(stall_cnt), 32'd5);
    chk("fill100_nbeats", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4 && i < beats.size(); i++)
      chk("fill100_beat", beats[i], 32'h100 + 32'(4 * i));
    chk("fill100_instr", instr_o, 32'hfeff_0100);

    nxt();
    addr_i = 32'h10c;
    @(negedge clk);
    chk("hit10c_hit", 32'(hit_o), 32'd1);
    chk("hit10c_stall", 32'(stall_o), 32'd0);
    chk("hit10c_instr", instr_o, 32'hfef3_010c);

    nxt();
    req_i  = 1'b0;
    addr_i = 32'h700;
    @(negedge clk);
    chk("noreq_stall", 32'(stall_o), 32'd0);

    // conflict on set 16
    nxt();
    stall_cnt = 0;
    req_i  = 1'b1;
    addr_i = 32'h500;
    wait_hit("fill500_timeout");
    chk("fill500_stalls", 32'(stall_cnt), 32'd5);
    chk("fill500_instr", instr_o, 32'hfaff_0500);
    nxt();
    addr_i = 32'h100;
    @(negedge clk);
    chk("evict100_hit", 32'(hit_o), 32'd0);
    chk("evict100_stall", 32'(stall_o), 32'd1);
    wait_hit("refill100_timeout");

    // ready low for 3 cycles on beat 2
    nxt();
    stall_cnt = 0;
    addr_i = 32'h300;
    nxt();
    nxt();
    nxt();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_addr", mem_addr_o, 32'h308);
      chk("hold_req", 32'(mem_req_o), 32'd1);
      nxt();
    end
    mem_ready_i = 1'b1;
    wait_hit("fill300_timeout");
    chk("fill300_stalls", 32'(stall_cnt), 32'd8);

    // invalidate during beat 1 of 0x200
    nxt();
    beats.delete();
    addr_i = 32'h200;
    nxt();
    nxt();
    invalidate_i = 1'b1;
    nxt();
    invalidate_i = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    chk("inv_nbeats", 32'(beats.size()), 32'd4);
    chk("inv200_hit", 32'(hit_o), 32'd0);
    chk("inv200_stall", 32'(stall_o), 32'd1);
    wait_hit("refill200_timeout");
    nxt();
    addr_i = 32'h100;
    @(negedge clk);
    chk("inv100_hit", 32'(hit_o), 32'd0);
    wait_hit("refill100b_timeout");

    // reset during beat 2
    nxt();
    addr_i = 32'h600;
    nxt();
    nxt();
    nxt();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mreq", 32'(mem_req_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    nxt();
    rst = 1'b1;
    beats.delete();
    addr_i = 32'h100;
    @(negedge clk);
    chk("post_rst_hit", 32'(hit_o), 32'd0);
    chk("post_rst_stall", 32'(stall_o), 32'd1);
    wait_hit("post_rst_timeout");
    chk("post_rst_nbeats", 32'(beats.size()), 32'd4);
    if (beats.size() > 0)
      chk("post_rst_beat0", beats[0], 32'h100);

    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
